// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encodings and
// default bus widths. Also consumed by the hazard unit and the trace monitor.
package pipeline_ctrl_pkg;

  localparam int unsigned DEF_XLEN  = 32;
  localparam int unsigned DEF_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MD_WAIT  = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones, synchronous active-high clear.
// Ports: clk, reset (sync, active-high), inc (count enable), count (current value).
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage RV32 pipeline.
// Merges load-use stall, EX branch redirect, data-memory wait, mul/div busy and trap
// requests into per-stage stall/flush enables and a single PC redirect. Redirects that
// arrive while MEM waits are held and replayed the cycle after the wait ends.
// Ports:
//   clk, reset (sync, active-high)
//   load_use_stall, branch_taken_EX/branch_target, trap_req/trap_vector,
//   mem_busy, muldiv_busy                                  -- requests in
//   stall_IF/ID/EX/MEM, flush_ID/EX/MEM                     -- stage controls out
//   pc_redirect/pc_target, muldiv_kill                      -- PC / mul-div control out
//   stall_cycles, flush_count                               -- perf counters out
// Outputs are combinational from state and inputs, forced to 0 while reset is high.
// Configuration: define PIPE_PERF_EN to build the saturating perf counters; otherwise
// stall_cycles and flush_count are tied to 0.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned XLEN  = DEF_XLEN,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use_stall,
  input  logic             branch_taken_EX,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             trap_req,
  input  logic [XLEN-1:0]  trap_vector,
  input  logic             mem_busy,
  input  logic             muldiv_busy,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             stall_EX,
  output logic             stall_MEM,
  output logic             flush_ID,
  output logic             flush_EX,
  output logic             flush_MEM,
  output logic             pc_redirect,
  output logic [XLEN-1:0]  pc_target,
  output logic             muldiv_kill,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_pend_valid;
  logic              r_pend_trap;
  logic [XLEN-1:0]   r_pend_target;
  logic              w_pend_valid_nxt;
  logic              w_pend_trap_nxt;
  logic [XLEN-1:0]   w_pend_target_nxt;

  logic              w_stall_if, w_stall_id, w_stall_ex, w_stall_mem;
  logic              w_flush_id, w_flush_ex, w_flush_mem;
  logic              w_redirect, w_kill;
  logic [XLEN-1:0]   w_target;

  // State and pending-redirect registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_pend_valid  <= 1'b0;
      r_pend_trap   <= 1'b0;
      r_pend_target <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pend_valid  <= w_pend_valid_nxt;
      r_pend_trap   <= w_pend_trap_nxt;
      r_pend_target <= w_pend_target_nxt;
    end
  end

  // Next-state, pending capture and stage controls
  always_comb begin
    w_state_nxt       = r_state;
    w_pend_valid_nxt  = r_pend_valid;
    w_pend_trap_nxt   = r_pend_trap;
    w_pend_target_nxt = r_pend_target;
    w_stall_if        = 1'b0;
    w_stall_id        = 1'b0;
    w_stall_ex        = 1'b0;
    w_stall_mem       = 1'b0;
    w_flush_id        = 1'b0;
    w_flush_ex        = 1'b0;
    w_flush_mem       = 1'b0;
    w_redirect        = 1'b0;
    w_kill            = 1'b0;
    w_target          = '0;

    case (r_state)
      ST_RUN: begin
        if (trap_req && !mem_busy) begin
          w_redirect  = 1'b1;
          w_target    = trap_vector;
          w_flush_id  = 1'b1;
          w_flush_ex  = 1'b1;
          w_flush_mem = 1'b1;
        end else if (mem_busy) begin
          w_stall_if  = 1'b1;
          w_stall_id  = 1'b1;
          w_stall_ex  = 1'b1;
          w_stall_mem = 1'b1;
          w_state_nxt = ST_MEM_WAIT;
          if (trap_req) begin
            w_pend_valid_nxt  = 1'b1;
            w_pend_trap_nxt   = 1'b1;
            w_pend_target_nxt = trap_vector;
          end else if (branch_taken_EX) begin
            w_pend_valid_nxt  = 1'b1;
            w_pend_trap_nxt   = 1'b0;
            w_pend_target_nxt = branch_target;
          end
        end else if (muldiv_busy) begin
          // The instruction in EX stays put; MEM receives bubbles until it completes.
          w_stall_if  = 1'b1;
          w_stall_id  = 1'b1;
          w_stall_ex  = 1'b1;
          w_flush_mem = 1'b1;
          w_state_nxt = ST_MD_WAIT;
        end else if (branch_taken_EX) begin
          w_redirect = 1'b1;
          w_target   = branch_target;
          w_flush_id = 1'b1;
          w_flush_ex = 1'b1;
        end else if (load_use_stall) begin
          w_stall_if = 1'b1;
          w_stall_id = 1'b1;
          w_flush_ex = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (mem_busy) begin
          w_stall_if  = 1'b1;
          w_stall_id  = 1'b1;
          w_stall_ex  = 1'b1;
          w_stall_mem = 1'b1;
          // A trap always replaces the pending entry; a branch never displaces a trap.
          if (trap_req) begin
            w_pend_valid_nxt  = 1'b1;
            w_pend_trap_nxt   = 1'b1;
            w_pend_target_nxt = trap_vector;
          end else if (branch_taken_EX && !r_pend_trap) begin
            w_pend_valid_nxt  = 1'b1;
            w_pend_trap_nxt   = 1'b0;
            w_pend_target_nxt = branch_target;
          end
        end else begin
          w_state_nxt = r_pend_valid ? ST_REDIRECT : ST_RUN;
        end
      end

      ST_REDIRECT: begin
        w_redirect        = 1'b1;
        w_target          = r_pend_target;
        w_flush_id        = 1'b1;
        w_flush_ex        = 1'b1;
        w_flush_mem       = r_pend_trap;
        w_pend_valid_nxt  = 1'b0;
        w_pend_trap_nxt   = 1'b0;
        w_pend_target_nxt = '0;
        w_state_nxt       = ST_RUN;
      end

      ST_MD_WAIT: begin
        if (trap_req) begin
          w_kill      = 1'b1;
          w_redirect  = 1'b1;
          w_target    = trap_vector;
          w_flush_id  = 1'b1;
          w_flush_ex  = 1'b1;
          w_flush_mem = 1'b1;
          w_state_nxt = ST_RUN;
        end else if (muldiv_busy) begin
          w_stall_if  = 1'b1;
          w_stall_id  = 1'b1;
          w_stall_ex  = 1'b1;
          w_flush_mem = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end

      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Outputs are quiet during reset
  assign stall_IF    = w_stall_if  & ~reset;
  assign stall_ID    = w_stall_id  & ~reset;
  assign stall_EX    = w_stall_ex  & ~reset;
  assign stall_MEM   = w_stall_mem & ~reset;
  assign flush_ID    = w_flush_id  & ~reset;
  assign flush_EX    = w_flush_ex  & ~reset;
  assign flush_MEM   = w_flush_mem & ~reset;
  assign pc_redirect = w_redirect  & ~reset;
  assign muldiv_kill = w_kill      & ~reset;
  assign pc_target   = reset ? '0 : w_target;

`ifdef PIPE_PERF_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_IF),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_redirect),
    .count (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: each step drives one cycle of requests, pushes the
// hand-derived expected controls to a scoreboard queue and pops/compares them mid-cycle.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic        sif, sid, sex, smem;
    logic        fid, fex, fmem;
    logic        red;
    logic [31:0] tgt;
    logic        kill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_use_stall, branch_taken_EX, trap_req, mem_busy, muldiv_busy;
  logic [31:0] branch_target, trap_vector;
  logic        stall_IF, stall_ID, stall_EX, stall_MEM;
  logic        flush_ID, flush_EX, flush_MEM, pc_redirect, muldiv_kill;
  logic [31:0] pc_target;
  logic [31:0] stall_cycles, flush_count;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  logic [31:0] exp_sc = '0;
  logic [31:0] exp_fc = '0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .load_use_stall  (load_use_stall),
    .branch_taken_EX (branch_taken_EX),
    .branch_target   (branch_target),
    .trap_req        (trap_req),
    .trap_vector     (trap_vector),
    .mem_busy        (mem_busy),
    .muldiv_busy     (muldiv_busy),
    .stall_IF        (stall_IF),
    .stall_ID        (stall_ID),
    .stall_EX        (stall_EX),
    .stall_MEM       (stall_MEM),
    .flush_ID        (flush_ID),
    .flush_EX        (flush_EX),
    .flush_MEM       (flush_MEM),
    .pc_redirect     (pc_redirect),
    .pc_target       (pc_target),
    .muldiv_kill     (muldiv_kill),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  // st = {IF,ID,EX,MEM} stalls, fl = {ID,EX,MEM} flushes
  function automatic exp_t mk(input logic [3:0] st, input logic [2:0] fl,
                              input logic red, input logic [31:0] tgt, input logic kill);
    exp_t e;
    {e.sif, e.sid, e.sex, e.smem} = st;
    {e.fid, e.fex, e.fmem}        = fl;
    e.red  = red;
    e.tgt  = tgt;
    e.kill = kill;
    return e;
  endfunction

  task automatic step(input string tag, input logic rst, input logic lu, input logic br,
                      input logic [31:0] bt, input logic tr, input logic [31:0] tv,
                      input logic mb, input logic md, input exp_t e);
    exp_t obs, req;
    @(negedge clk);
    reset = rst; load_use_stall = lu; branch_taken_EX = br; branch_target = bt;
    trap_req = tr; trap_vector = tv; mem_busy = mb; muldiv_busy = md;
    if (md && br) begin
      errors++;
      $error("FAIL illegal_md_branch stimulus drives muldiv_busy with branch_taken_EX");
    end
    sb.push_back(e);
    #1;
    checks++;
    assert (stall_cycles === exp_sc) else begin
      errors++;
      $error("FAIL %s.stall_cycles observed=%0d expected=%0d", tag, stall_cycles, exp_sc);
    end
    checks++;
    assert (flush_count === exp_fc) else begin
      errors++;
      $error("FAIL %s.flush_count observed=%0d expected=%0d", tag, flush_count, exp_fc);
    end
    req = sb.pop_front();
    obs = {stall_IF, stall_ID, stall_EX, stall_MEM, flush_ID, flush_EX, flush_MEM,
           pc_redirect, pc_target, muldiv_kill};
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
    @(posedge clk);
`ifdef PIPE_PERF_EN
    if (rst) begin
      exp_sc = '0;
      exp_fc = '0;
    end else begin
      if (e.sif && exp_sc != '1) exp_sc = exp_sc + 32'd1;
      if (e.red && exp_fc != '1) exp_fc = exp_fc + 32'd1;
    end
`endif
  endtask

  initial begin
    exp_t Z, S4, LU, MD;
    Z  = mk(4'b0000, 3'b000, 1'b0, 32'h0, 1'b0);
    S4 = mk(4'b1111, 3'b000, 1'b0, 32'h0, 1'b0);
    LU = mk(4'b1100, 3'b010, 1'b0, 32'h0, 1'b0);
    MD = mk(4'b1110, 3'b001, 1'b0, 32'h0, 1'b0);

    // Reset: outputs quiet even with active requests
    step("rst0", 1, 1, 0, 32'h0, 1, 32'h80, 1, 0, Z);
    step("rst1", 1, 0, 1, 32'h100, 0, 32'h0, 0, 0, Z);
    step("idle", 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, Z);

    // Load-use: one bubble, one cycle only
    step("lu", 0, 1, 0, 32'h0, 0, 32'h0, 0, 0, LU);
    step("lu_after", 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, Z);

    // Branch: zero-latency redirect
    step("br", 0, 0, 1, 32'h100, 0, 32'h0, 0, 0, mk(4'b0000, 3'b110, 1, 32'h100, 0));

    // Deferred branch across a 3-cycle memory wait
    step("dbr_c0", 0, 0, 0, 32'h0, 0, 32'h0, 1, 0, S4);
    step("dbr_c1", 0, 0, 1, 32'h200, 0, 32'h0, 1, 0, S4);
    step("dbr_c2", 0, 0, 0, 32'h0, 0, 32'h0, 1, 0, S4);
    step("dbr_fall", 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, Z);
    step("dbr_replay", 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, mk(4'b0000, 3'b110, 1, 32'h200, 0));
    step("dbr_after", 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, Z);

    // Trap beats branch during memory wait; later branch cannot displace it
    step("tb_c0", 0, 0, 0, 32'h0, 0, 32'h0, 1, 0, S4);
    step("tb_br", 0, 0, 1, 32'h300, 0, 32'h0, 1, 0, S4);
    step("tb_trap", 0, 0, 0, 32'h0, 1, 32'h80, 1, 0, S4);
    step("tb_br2", 0, 0, 1, 32'h400, 0, 32'h0, 1, 0, S4);
    step("tb_fall", 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, Z);
    step("tb_replay", 0, 1, 1, 32'h500, 0, 32'h0, 0, 0, mk(4'b0000, 3'b111, 1, 32'h80, 0));
    step("tb_after", 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, Z);

    // Trap in RUN, memory idle: immediate redirect
    step("trap_run", 0, 0, 1, 32'h600, 1, 32'h44, 0, 0, mk(4'b0000, 3'b111, 1, 32'h44, 0));

    // Trap with memory busy in RUN: deferred trap replay flushes MEM
    step("tm_c0", 0, 0, 0, 32'h0, 1, 32'h48, 1, 0, S4);
    step("tm_fall", 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, Z);
    step("tm_replay", 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, mk(4'b0000, 3'b111, 1, 32'h48, 0));

    // Memory wait with nothing pending returns to RUN; next branch is immediate
    step("mw_c0", 0, 0, 0, 32'h0, 0, 32'h0, 1, 0, S4);
    step("mw_c1", 0, 0, 0, 32'h0, 0, 32'h0, 1, 0, S4);
    step("mw_fall", 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, Z);
    step("mw_br", 0, 0, 1, 32'h700, 0, 32'h0, 0, 0, mk(4'b0000, 3'b110, 1, 32'h700, 0));

    // Mem beats muldiv in RUN
    step("mem_md", 0, 0, 0, 32'h0, 0, 32'h0, 1, 1, S4);
    step("mem_md_fall", 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, Z);

    // Mul/div completes normally
    step("md_c0", 0, 0, 0, 32'h0, 0, 32'h0, 0, 1, MD);
    step("md_c1", 0, 1, 0, 32'h0, 0, 32'h0, 0, 1, MD);
    step("md_done", 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, Z);

    // Mul/div abort by trap at cycle 2 of 5
    step("mk_c0", 0, 0, 0, 32'h0, 0, 32'h0, 0, 1, MD);
    step("mk_c1", 0, 0, 0, 32'h0, 0, 32'h0, 0, 1, MD);
    step("mk_trap", 0, 0, 0, 32'h0, 1, 32'hC0, 0, 1, mk(4'b0000, 3'b111, 1, 32'hC0, 1));
    step("mk_after", 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, Z);
    step("mk_br", 0, 0, 1, 32'h800, 0, 32'h0, 0, 0, mk(4'b0000, 3'b110, 1, 32'h800, 0));

    // Reset in MEM_WAIT with a pending branch discards it
    step("rm_c0", 0, 0, 0, 32'h0, 0, 32'h0, 1, 0, S4);
    step("rm_br", 0, 0, 1, 32'h900, 0, 32'h0, 1, 0, S4);
    step("rm_rst", 1, 0, 1, 32'h900, 0, 32'h0, 1, 0, Z);
    step("rm_post0", 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, Z);
    step("rm_post1", 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, Z);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
